// File: rtl/vtw_contention_pkg.sv
// vtw_contention_pkg: pin indices, FSM states and event record shared by the contention logger.
package vtw_contention_pkg;
    localparam int PIN_SCL  = 0;
    localparam int PIN_SDA  = 1;
    localparam int DROP_W   = 8;
    localparam int TS_W_MAX = 32;

    typedef enum logic {ST_IDLE, ST_CONTEND} cstate_e;

    typedef struct packed {
        logic                pin;
        logic                data;
        logic [TS_W_MAX-1:0] ts;
    } evt_t;
endpackage

// File: rtl/vtw_event_fifo.sv
// vtw_event_fifo: dual-push, single-pop, show-ahead FIFO; push1 is only ever used together with push0.
module vtw_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push0,
    input  logic [W-1:0]             wdata0,
    input  logic                     push1,
    input  logic [W-1:0]             wdata1,
    input  logic                     pop,
    output logic                     valid,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    assign valid  = cnt_q != '0;
    assign do_pop = pop & valid;
    // Empty FIFO presents zeros so the head fields are defined in and after reset.
    assign rdata  = valid ? mem_q[rp_q] : '0;
    assign count  = cnt_q;

    always_comb begin
        wp_d  = wp_q + AW'(push0) + AW'(push1);
        rp_d  = rp_q + AW'(do_pop);
        cnt_d = cnt_q + CW'(push0) + CW'(push1) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem_q[wp_q] <= wdata0;
        if (push1) mem_q[wp_q + AW'(1)] <= wdata1;
    end
endmodule

// File: rtl/vtw_contention_log.sv
// vtw_contention_log: logs the start of each I2C SCL/SDA drive contention episode with a timestamp.
// Define VTW_OE_CONTENTION_MONITOR_EN to detect contention as drv_en & oe instead of drv_en & pin!=drv_data.
module vtw_contention_log
    import vtw_contention_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_drv_en,
    input  logic              scl_drv_data,
    input  logic              scl_pin,
    input  logic              scl_oe,
    input  logic              sda_drv_en,
    input  logic              sda_drv_data,
    input  logic              sda_pin,
    input  logic              sda_oe,
    input  logic              clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              evt_pin,
    output logic              evt_data,
    output logic [TS_W-1:0]   evt_ts,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int W  = TS_W + 2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]        drv_en, drv_data, pin_v, oe, cond, det;
    cstate_e           st_q [2];
    cstate_e           st_d [2];
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;
    logic [1:0]        n_drop;
    logic              push0, push1;
    logic [W-1:0]      wdata0, wdata1, rdata;
    logic [CW-1:0]     fifo_cnt;

    assign drv_en   = {sda_drv_en, scl_drv_en};
    assign drv_data = {sda_drv_data, scl_drv_data};
    assign pin_v    = {sda_pin, scl_pin};
    assign oe       = {sda_oe, scl_oe};

`ifdef VTW_OE_CONTENTION_MONITOR_EN
    logic unused_pin;
    assign cond       = drv_en & oe;
    assign unused_pin = ^pin_v;
`else
    logic unused_oe;
    assign cond      = drv_en & (pin_v ^ drv_data);
    assign unused_oe = ^oe;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= '{ST_IDLE, ST_IDLE};
        else        st_q <= st_d;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            st_d[p] = cond[p] ? ST_CONTEND : ST_IDLE;
            det[p]  = cond[p] && (st_q[p] == ST_IDLE);
        end
    end

    // Space is judged on start-of-cycle occupancy; SCL always takes the first slot.
    always_comb begin
        push0    = (|det) && (fifo_cnt < CW'(DEPTH));
        push1    = (&det) && (fifo_cnt <= CW'(DEPTH - 2));
        wdata0   = det[PIN_SCL] ? {1'(PIN_SCL), scl_drv_data, ts_q} : {1'(PIN_SDA), sda_drv_data, ts_q};
        wdata1   = {1'(PIN_SDA), sda_drv_data, ts_q};
        n_drop   = 2'(det[0]) + 2'(det[1]) - 2'(push0) - 2'(push1);
        drop_sum = {1'b0, drop_q} + (DROP_W + 1)'(n_drop);
        ts_d     = clr ? '0 : ts_q + TS_W'(1);
        ovf_d    = clr ? 1'b0 : ovf_q | (n_drop != 2'd0);
        drop_d   = clr ? '0 : drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            ts_q   <= ts_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    vtw_event_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push0  (push0),
        .wdata0 (wdata0),
        .push1  (push1),
        .wdata1 (wdata1),
        .pop    (evt_ready),
        .valid  (evt_valid),
        .rdata  (rdata),
        .count  (fifo_cnt)
    );

    assign evt_pin  = rdata[W-1];
    assign evt_data = rdata[W-2];
    assign evt_ts   = rdata[TS_W-1:0];
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;
endmodule
